image_input_loader: RTL and testbench

Front-end stage that sits directly upstream of the network compute stage. It accepts a stream of grey-scale pixels over a valid/ready handshake, binarizes each pixel against a fixed threshold, and writes the resulting 1-bit activations into activation bank 0 at consecutive addresses. Once a full frame is stored, it raises the compute enable, holds it until the compute stage reports completion, then returns to idle for the next frame.

---
 rtl/image_input_loader_pkg.sv | 16 +
 rtl/image_input_loader_pixel_binarizer.sv | 35 +++
 rtl/image_input_loader.sv | 119 +++++++++++
 tb/tb_image_input_loader.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/image_input_loader_pkg.sv
// Shared definitions for the image input loader: FSM state encoding and the
// activation bank that holds the binarized input image.
package image_input_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_DONE   = 3'd4
  } loader_state_t;

  // Bank 0 holds the input layer; the compute stage and memory model agree on this.
  localparam int X_BANK_INPUT = 0;

endpackage

// File: rtl/image_input_loader_pixel_binarizer.sv
// Registered threshold compare turning a grey-scale pixel into a 1-bit activation.
// With LOADER_ONES_COUNT_EN defined it also exposes the ones-count increment.
module pixel_binarizer #(
  parameter int PIX_W  = 8,
  parameter int THRESH = 128
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [PIX_W-1:0] pix_data,
  output logic             bit_q
`ifdef LOADER_ONES_COUNT_EN
  ,
  output logic             ones_inc
`endif
);

  logic is_one;

  assign is_one = (pix_data >= PIX_W'(THRESH));

  // Holds the last accepted activation so x_wdata stays stable between writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_q <= 1'b0;
    end else if (load) begin
      bit_q <= is_one;
    end
  end

`ifdef LOADER_ONES_COUNT_EN
  assign ones_inc = load & is_one;
`endif

endmodule

// File: rtl/image_input_loader.sv
// Loads one binarized frame into activation bank 0, then enables the compute stage
// until it finishes. Optional feature: LOADER_ONES_COUNT_EN adds the ones_count output.
module image_input_loader
  import image_input_loader_pkg::*;
#(
  parameter int X_ADDR_LEN = 10,
  parameter int X_SEL_LEN  = 2,
  parameter int X1_LEN     = 2,
  parameter int PIX_W      = 8,
  parameter int THRESH     = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  pix_valid,
  input  logic [PIX_W-1:0]      pix_data,
  output logic                  pix_ready,
  output logic [X_ADDR_LEN-1:0] x_addr,
  output logic [X_SEL_LEN-1:0]  x_sel,
  output logic                  x_wq,
  output logic                  x_wdata,
  output logic                  compute_en,
  input  logic                  compute_finish,
  output logic                  busy,
  output logic                  done
`ifdef LOADER_ONES_COUNT_EN
  ,
  output logic [X_ADDR_LEN:0]   ones_count
`endif
);

  localparam logic [X_ADDR_LEN-1:0] LAST_ADDR = X_ADDR_LEN'(X1_LEN - 1);

  loader_state_t         state, state_next;
  logic [X_ADDR_LEN-1:0] cnt;
  logic                  handshake;
  logic                  start_accept;

  assign handshake    = pix_valid & pix_ready;
  assign start_accept = (state == ST_IDLE) & start;
  assign x_sel        = X_SEL_LEN'(X_BANK_INPUT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (start) state_next = ST_LOAD;
      ST_LOAD:   if (handshake && cnt == LAST_ADDR) state_next = ST_SETTLE;
      ST_SETTLE: state_next = ST_RUN;
      ST_RUN:    if (compute_finish) state_next = ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they are flops aligned with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pix_ready  <= 1'b0;
      compute_en <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      x_wq       <= 1'b0;
      x_addr     <= '0;
      cnt        <= '0;
    end else begin
      pix_ready  <= (state_next == ST_LOAD);
      compute_en <= (state_next == ST_RUN);
      busy       <= (state_next != ST_IDLE);
      done       <= (state_next == ST_DONE);
      x_wq       <= handshake;
      if (handshake) x_addr <= cnt;
      if (start_accept) begin
        cnt <= '0;
      end else if (handshake) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

`ifdef LOADER_ONES_COUNT_EN
  logic ones_inc;

  pixel_binarizer #(.PIX_W(PIX_W), .THRESH(THRESH)) u_binarizer (
    .clk      (clk),
    .rst      (rst),
    .load     (handshake),
    .pix_data (pix_data),
    .bit_q    (x_wdata),
    .ones_inc (ones_inc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ones_count <= '0;
    end else if (start_accept) begin
      ones_count <= '0;
    end else if (ones_inc) begin
      ones_count <= ones_count + 1'b1;
    end
  end
`else
  pixel_binarizer #(.PIX_W(PIX_W), .THRESH(THRESH)) u_binarizer (
    .clk      (clk),
    .rst      (rst),
    .load     (handshake),
    .pix_data (pix_data),
    .bit_q    (x_wdata)
  );
`endif

endmodule

// File: tb/tb_image_input_loader.sv
// Directed testbench for image_input_loader (X1_LEN=2, THRESH=128).
module tb_image_input_loader;

  logic       clk;
  logic       rst;
  logic       start;
  logic       pix_valid;
  logic [7:0] pix_data;
  logic       pix_ready;
  logic [9:0] x_addr;
  logic [1:0] x_sel;
  logic       x_wq;
  logic       x_wdata;
  logic       compute_en;
  logic       compute_finish;
  logic       busy;
  logic       done;
`ifdef LOADER_ONES_COUNT_EN
  logic [10:0] ones_count;
`endif

  int vectors;
  int miscompares;

  image_input_loader #(
    .X_ADDR_LEN(10), .X_SEL_LEN(2), .X1_LEN(2), .PIX_W(8), .THRESH(128)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .pix_valid      (pix_valid),
    .pix_data       (pix_data),
    .pix_ready      (pix_ready),
    .x_addr         (x_addr),
    .x_sel          (x_sel),
    .x_wq           (x_wq),
    .x_wdata        (x_wdata),
    .compute_en     (compute_en),
    .compute_finish (compute_finish),
    .busy           (busy),
    .done           (done)
`ifdef LOADER_ONES_COUNT_EN
    ,
    .ones_count     (ones_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; outputs are sampled and inputs driven 1 unit later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; pix_valid = 1'b0; pix_data = 8'd0; compute_finish = 1'b0;
    #1 rst = 1'b0;
    tick(); tick();
    vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_pix_ready: got %b want 0", pix_ready); end
    vectors++; if (x_wq !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_x_wq: got %b want 0", x_wq); end
    vectors++; if (x_wdata !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_x_wdata: got %b want 0", x_wdata); end
    vectors++; if (x_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_x_addr: got %0d want 0", x_addr); end
    vectors++; if (x_sel !== 2'd0) begin miscompares++; $display("[TB] FAIL reset_x_sel: got %0d want 0", x_sel); end
    vectors++; if (compute_en !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_compute_en: got %b want 0", compute_en); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_done: got %b want 0", done); end
`ifdef LOADER_ONES_COUNT_EN
    vectors++; if (ones_count !== 11'd0) begin miscompares++; $display("[TB] FAIL reset_ones_count: got %0d want 0", ones_count); end
`endif
    rst = 1'b1;
    tick();
  endtask

  task automatic test_frame_load();
    start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (pix_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL load_ready: got %b want 1", pix_ready); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL load_busy: got %b want 1", busy); end
    pix_valid = 1'b1; pix_data = 8'd200;
    tick();
    vectors++; if (x_wq !== 1'b1) begin miscompares++; $display("[TB] FAIL load_wq0: got %b want 1", x_wq); end
    vectors++; if (x_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL load_addr0: got %0d want 0", x_addr); end
    vectors++; if (x_wdata !== 1'b1) begin miscompares++; $display("[TB] FAIL load_data0: got %b want 1", x_wdata); end
    vectors++; if (x_sel !== 2'd0) begin miscompares++; $display("[TB] FAIL load_sel: got %0d want 0", x_sel); end
    pix_data = 8'd50;
    tick();
    pix_valid = 1'b0;
    vectors++; if (x_wq !== 1'b1) begin miscompares++; $display("[TB] FAIL load_wq1: got %b want 1", x_wq); end
    vectors++; if (x_addr !== 10'd1) begin miscompares++; $display("[TB] FAIL load_addr1: got %0d want 1", x_addr); end
    vectors++; if (x_wdata !== 1'b0) begin miscompares++; $display("[TB] FAIL load_data1: got %b want 0", x_wdata); end
    vectors++; if (pix_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL settle_ready: got %b want 0", pix_ready); end
    vectors++; if (compute_en !== 1'b0) begin miscompares++; $display("[TB] FAIL settle_compute_en: got %b want 0", compute_en); end
    tick();
    vectors++; if (compute_en !== 1'b1) begin miscompares++; $display("[TB] FAIL run_compute_en: got %b want 1", compute_en); end
    vectors++; if (x_wq !== 1'b0) begin miscompares++; $display("[TB] FAIL run_x_wq: got %b want 0", x_wq); end
  endtask

  task automatic test_completion();
    tick();
    vectors++; if (compute_en !== 1'b1) begin miscompares++; $display("[TB] FAIL run_hold_compute_en: got %b want 1", compute_en); end
    compute_finish = 1'b1;
    tick();
    compute_finish = 1'b0;
    vectors++; if (compute_en !== 1'b0) begin miscompares++; $display("[TB] FAIL done_compute_en: got %b want 0", compute_en); end
    vectors++; if (done !== 1'b1) begin miscompares++; $display("[TB] FAIL done_pulse: got %b want 1", done); end
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("[TB] FAIL done_busy: got %b want 1", busy); end
    tick();
    vectors++; if (done !== 1'b0) begin miscompares++; $display("[TB] FAIL done_one_cycle: got %b want 0", done); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_busy: got %b want 0", busy); end
  endtask

  task automatic test_stall();
    start = 1'b1;
    tick();
    start = 1'b0;
    pix_valid = 1'b1; pix_data = 8'd200;
    tick();
    pix_valid = 1'b0;
    vectors++; if (x_wq !== 1'b1 || x_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL stall_first_write: got wq=%b addr=%0d want wq=1 addr=0", x_wq, x_addr); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (x_wq !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_gap_wq%0d: got %b want 0", i, x_wq); end
      vectors++; if (pix_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL stall_gap_ready%0d: got %b want 1", i, pix_ready); end
    end
    pix_valid = 1'b1; pix_data = 8'd50;
    tick();
    pix_valid = 1'b0;
    vectors++; if (x_wq !== 1'b1 || x_addr !== 10'd1 || x_wdata !== 1'b0) begin miscompares++; $display("[TB] FAIL stall_second_write: got wq=%b addr=%0d data=%b want wq=1 addr=1 data=0", x_wq, x_addr, x_wdata); end
    tick();
    compute_finish = 1'b1;
    tick();
    compute_finish = 1'b0;
    tick();
  endtask

  task automatic test_threshold_edges();
    start = 1'b1;
    tick();
    start = 1'b0;
    pix_valid = 1'b1; pix_data = 8'd127;
    tick();
    vectors++; if (x_wdata !== 1'b0) begin miscompares++; $display("[TB] FAIL thresh_127: got %b want 0", x_wdata); end
    pix_data = 8'd128;
    tick();
    pix_valid = 1'b0;
    vectors++; if (x_wdata !== 1'b1) begin miscompares++; $display("[TB] FAIL thresh_128: got %b want 1", x_wdata); end
`ifdef LOADER_ONES_COUNT_EN
    vectors++; if (ones_count !== 11'd1) begin miscompares++; $display("[TB] FAIL ones_count_settle: got %0d want 1", ones_count); end
`endif
    tick();
    compute_finish = 1'b1;
    tick();
    compute_finish = 1'b0;
    tick();
  endtask

  task automatic test_ignored_inputs();
    pix_valid = 1'b1; pix_data = 8'd30; compute_finish = 1'b1;
    tick(); tick();
    compute_finish = 1'b0;
    vectors++; if (pix_ready !== 1'b0 || x_wq !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_valid_ignored: got ready=%b wq=%b want 0 0", pix_ready, x_wq); end
    vectors++; if (busy !== 1'b0 || done !== 1'b0) begin miscompares++; $display("[TB] FAIL idle_finish_ignored: got busy=%b done=%b want 0 0", busy, done); end
    start = 1'b1;
    tick();
    vectors++; if (x_wq !== 1'b0) begin miscompares++; $display("[TB] FAIL start_edge_no_write: got %b want 0", x_wq); end
    tick();
    vectors++; if (x_wq !== 1'b1 || x_addr !== 10'd0 || x_wdata !== 1'b0) begin miscompares++; $display("[TB] FAIL ign_write0: got wq=%b addr=%0d data=%b want 1 0 0", x_wq, x_addr, x_wdata); end
    pix_data = 8'd255;
    tick();
    pix_valid = 1'b0;
    vectors++; if (x_wq !== 1'b1 || x_addr !== 10'd1 || x_wdata !== 1'b1) begin miscompares++; $display("[TB] FAIL ign_start_in_load: got wq=%b addr=%0d data=%b want 1 1 1", x_wq, x_addr, x_wdata); end
    tick();
    start = 1'b0;
    vectors++; if (compute_en !== 1'b1) begin miscompares++; $display("[TB] FAIL ign_run_compute_en: got %b want 1", compute_en); end
  endtask

  task automatic test_mid_reset();
    #2 rst = 1'b0;
    #1;
    vectors++; if (compute_en !== 1'b0) begin miscompares++; $display("[TB] FAIL async_compute_en: got %b want 0", compute_en); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("[TB] FAIL async_busy: got %b want 0", busy); end
    vectors++; if (x_wq !== 1'b0 || x_addr !== 10'd0) begin miscompares++; $display("[TB] FAIL async_write: got wq=%b addr=%0d want 0 0", x_wq, x_addr); end
    tick();
    rst = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0 || pix_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_idle: got busy=%b ready=%b want 0 0", busy, pix_ready); end
    start = 1'b1;
    tick();
    start = 1'b0;
    pix_valid = 1'b1; pix_data = 8'd129;
    tick();
    vectors++; if (x_wq !== 1'b1 || x_addr !== 10'd0 || x_wdata !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_addr0: got wq=%b addr=%0d data=%b want 1 0 1", x_wq, x_addr, x_wdata); end
    pix_data = 8'd0;
    tick();
    pix_valid = 1'b0;
    vectors++; if (x_wq !== 1'b1 || x_addr !== 10'd1 || x_wdata !== 1'b0) begin miscompares++; $display("[TB] FAIL post_reset_addr1: got wq=%b addr=%0d data=%b want 1 1 0", x_wq, x_addr, x_wdata); end
    tick();
    vectors++; if (compute_en !== 1'b1) begin miscompares++; $display("[TB] FAIL post_reset_run: got %b want 1", compute_en); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_frame_load();
    test_completion();
    test_stall();
    test_threshold_edges();
    test_ignored_inputs();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
